// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: round/step controller for the multicycle AES-128/192/256 datapath
// Ports: clk/rst_n (async active-low); in_valid_i/in_ready_o accept a block, key_mode_i picks the key size;
// out_valid_o/out_ready_i hand off the ciphertext; abort_i flushes to idle; load_input_o, round_step_o,
// round_index_o, last_round_o, enable_ks_o drive the datapath and key schedule; busy_o flags activity.
module aes_round_sequencer #(
  parameter int STEPS_PER_ROUND  = 3,
  parameter int LAST_ROUND_STEPS = 2,
  localparam int STEP_W = (STEPS_PER_ROUND > 1) ? $clog2(STEPS_PER_ROUND) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        key_mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  input  logic              abort_i,
  output logic              load_input_o,
  output logic [STEP_W-1:0] round_step_o,
  output logic [3:0]        round_index_o,
  output logic              last_round_o,
  output logic              enable_ks_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [STEP_W-1:0] FULL_MAX = STEP_W'(STEPS_PER_ROUND - 1);
  localparam logic [STEP_W-1:0] LAST_MAX = STEP_W'(LAST_ROUND_STEPS - 1);
  state_e st_q, st_d;
  logic [3:0] idx_q, idx_d, nr;
  logic [STEP_W-1:0] step_q, step_d, step_max;
  logic [1:0] mode_q, mode_d;
  logic run, last, bad, out_xfer;
  always_comb begin
    nr           = mode_q == 2'd1 ? 4'd12 : mode_q == 2'd2 ? 4'd14 : 4'd10;
    run          = st_q == RUN;
    last         = idx_q == nr;
    step_max     = last ? LAST_MAX : FULL_MAX;
    // counter values the sequence can never produce; treated as corruption
    bad          = idx_q == 4'd0 || idx_q > nr || step_q > step_max;
    // abort masks acceptance even when a DONE hand-off would otherwise allow it
    in_ready_o   = !abort_i && (st_q == IDLE || (st_q == DONE && out_ready_i));
    load_input_o = in_valid_i && in_ready_o;
    out_valid_o  = st_q == DONE;
    out_xfer     = out_valid_o && out_ready_i;
    round_step_o = run ? step_q : '0;
    round_index_o = run ? idx_q : 4'd0;
    last_round_o = run && last;
    enable_ks_o  = run && step_q == '0;
    busy_o       = st_q != IDLE;
  end
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    step_d = step_q;
    mode_d = mode_q;
    if (abort_i) begin
      st_d   = IDLE;
      idx_d  = 4'd0;
      step_d = '0;
    end else if (load_input_o) begin
      // covers both the IDLE accept and the back-to-back accept in DONE
      st_d   = RUN;
      idx_d  = 4'd1;
      step_d = '0;
      mode_d = key_mode_i == 2'd3 ? 2'd0 : key_mode_i;
    end else begin
      case (st_q)
        RUN: begin
          if (bad) begin
            st_d   = IDLE;
            idx_d  = 4'd0;
            step_d = '0;
          end else if (step_q != step_max) begin
            step_d = step_q + STEP_W'(1);
          end else if (last) begin
            st_d   = DONE;
            idx_d  = 4'd0;
            step_d = '0;
          end else begin
            step_d = '0;
            idx_d  = idx_q + 4'd1;
          end
        end
        DONE: begin
          if (out_xfer || idx_q != 4'd0 || step_q != '0) begin
            st_d   = IDLE;
            idx_d  = 4'd0;
            step_d = '0;
          end
        end
        default: begin
          st_d   = IDLE;
          idx_d  = 4'd0;
          step_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      idx_q  <= 4'd0;
      step_q <= '0;
      mode_q <= 2'd0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      step_q <= step_d;
      mode_q <= mode_d;
    end
  end
endmodule
